// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply/divide unit holding the architectural HI/LO registers.
// Signed ops run on magnitudes; the sign is restored in a single FIX cycle.
module muldiv_unit #(
  parameter int ITER = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        muldiv_we,
  input  logic [2:0]  muldiv_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy
);

  // state | meaning
  // IDLE  | waiting for a command; mthi/mtlo complete here
  // CALC  | one shift-add / shift-subtract step per cycle, ITER cycles
  // FIX   | sign correction, HI/LO written together
  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

  localparam int CW = $clog2(ITER);

  state_t         state, state_nx;
  logic [CW-1:0]  cnt;
  logic           is_div, neg_q, neg_r;
  logic [32:0]    acc_hi;
  logic [31:0]    acc_lo, op_b;

  logic           accept, signed_op, a_neg, b_neg;
  logic [31:0]    a_mag, b_mag;
  logic [32:0]    mul_sum;
  logic [64:0]    mul_cat, mul_sh;
  logic [32:0]    rem_sh, rem_diff;
  logic           rem_ge;
  logic [63:0]    prod, prod_fix;
  logic [31:0]    quo_fix, rem_fix;

  assign accept    = muldiv_we && !busy;
  assign signed_op = ~muldiv_op[0];
  assign a_neg     = signed_op && a[31];
  assign b_neg     = signed_op && b[31];
  assign a_mag     = a_neg ? (~a + 32'd1) : a;
  assign b_mag     = b_neg ? (~b + 32'd1) : b;

  // Multiply step: add multiplicand when multiplier LSB is set, then shift right.
  assign mul_sum = {1'b0, acc_hi[31:0]} + (acc_lo[0] ? {1'b0, op_b} : 33'd0);
  assign mul_cat = {mul_sum, acc_lo};
  assign mul_sh  = mul_cat >> 1;

  // Restoring divide step: remainder lives in acc_hi, quotient shifts into acc_lo.
  assign rem_sh   = {acc_hi[31:0], acc_lo[31]};
  assign rem_ge   = rem_sh >= {1'b0, op_b};
  assign rem_diff = rem_sh - {1'b0, op_b};

  assign prod     = {acc_hi[31:0], acc_lo};
  assign prod_fix = neg_q ? (~prod + 64'd1) : prod;
  assign quo_fix  = neg_q ? (~acc_lo + 32'd1) : acc_lo;
  assign rem_fix  = neg_r ? (~acc_hi[31:0] + 32'd1) : acc_hi[31:0];

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (accept && !muldiv_op[2]) state_nx = S_CALC;
      S_CALC: if (cnt == CW'(ITER - 1)) state_nx = S_FIX;
      S_FIX:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      busy   <= 1'b0;
      hi     <= 32'd0;
      lo     <= 32'd0;
      cnt    <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      acc_hi <= 33'd0;
      acc_lo <= 32'd0;
      op_b   <= 32'd0;
    end else begin
      state <= state_nx;
      busy  <= (state_nx != S_IDLE);
      case (state)
        S_IDLE: begin
          if (accept) begin
            case (muldiv_op)
              3'b100: hi <= a;
              3'b101: lo <= a;
              3'b000, 3'b001, 3'b010, 3'b011: begin
                acc_hi <= 33'd0;
                acc_lo <= a_mag;
                op_b   <= b_mag;
                is_div <= muldiv_op[1];
                neg_q  <= a_neg ^ b_neg;
                neg_r  <= a_neg;
                cnt    <= '0;
              end
              default: ;
            endcase
          end
        end
        S_CALC: begin
          cnt <= cnt + 1'b1;
          if (is_div) begin
            acc_hi <= rem_ge ? {1'b0, rem_diff[31:0]} : {1'b0, rem_sh[31:0]};
            acc_lo <= {acc_lo[30:0], rem_ge};
          end else begin
            acc_hi <= mul_sh[64:32];
            acc_lo <= mul_sh[31:0];
          end
        end
        S_FIX: begin
          // With a zero divisor every step subtracts nothing, so the remainder
          // ends up as |a| and sign-fixes back to a; only LO needs forcing.
          if (is_div) begin
            hi <= rem_fix;
            lo <= (op_b == 32'd0) ? 32'hFFFF_FFFF : quo_fix;
          end else begin
            hi <= prod_fix[63:32];
            lo <= prod_fix[31:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit: reset, mult/div signs,
// divide by zero, overflow, ignore-while-busy, mt* and reserved ops.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        muldiv_we;
  logic [2:0]  muldiv_op;
  logic [31:0] a, b;
  logic [31:0] hi, lo;
  logic        busy;

  int total  = 0;
  int passed = 0;

  muldiv_unit #(.ITER(32)) dut (
    .clk(clk), .reset(reset), .muldiv_we(muldiv_we), .muldiv_op(muldiv_op),
    .a(a), .b(b), .hi(hi), .lo(lo), .busy(busy)
  );

  always #5 clk = ~clk;

  // Issues one command, scrambles operands after the accept edge, and waits
  // (bounded) for busy to fall. Returns the number of busy-high cycles.
  task automatic do_op(input logic [2:0] op, input logic [31:0] va, input logic [31:0] vb,
                       output int cyc);
    @(negedge clk);
    muldiv_we = 1'b1; muldiv_op = op; a = va; b = vb;
    @(posedge clk); #1;
    muldiv_we = 1'b0; a = 32'hDEAD_BEEF; b = 32'h1357_9BDF;
    cyc = 0;
    while (busy && cyc < 60) begin
      cyc++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; muldiv_we = 1'b0; muldiv_op = 3'b000; a = 32'd0; b = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (hi !== 32'd0) $display("FAIL reset_hi: got %h want %h", hi, 32'd0); else passed++;
    total++; if (lo !== 32'd0) $display("FAIL reset_lo: got %h want %h", lo, 32'd0); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passed++;
    reset = 1'b0;
  endtask

  task automatic test_reset_mid_op();
    int cyc;
    do_op(3'b100, 32'd5, 32'd0, cyc);
    total++; if (hi !== 32'd5) $display("FAIL mthi_5: got %h want %h", hi, 32'd5); else passed++;
    @(negedge clk);
    muldiv_we = 1'b1; muldiv_op = 3'b001; a = 32'd3; b = 32'd4;
    @(posedge clk); #1;            // E0
    muldiv_we = 1'b0;
    repeat (9) @(posedge clk);     // E9
    #1;
    reset = 1'b1;
    @(posedge clk); #1;            // E10 with reset
    reset = 1'b0;
    total++; if (hi !== 32'd0) $display("FAIL rstmid_hi: got %h want %h", hi, 32'd0); else passed++;
    total++; if (lo !== 32'd0) $display("FAIL rstmid_lo: got %h want %h", lo, 32'd0); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL rstmid_busy: got %b want 0", busy); else passed++;
    repeat (40) @(posedge clk);
    #1;
    total++; if (lo !== 32'd0) $display("FAIL rstmid_lo_later: got %h want %h", lo, 32'd0); else passed++;
  endtask

  task automatic test_multu_overflow();
    int cyc;
    do_op(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, cyc);
    total++; if (cyc !== 33) $display("FAIL multu_busy_cycles: got %0d want 33", cyc); else passed++;
    total++; if (hi !== 32'hFFFF_FFFE) $display("FAIL multu_hi: got %h want %h", hi, 32'hFFFF_FFFE); else passed++;
    total++; if (lo !== 32'h0000_0001) $display("FAIL multu_lo: got %h want %h", lo, 32'h0000_0001); else passed++;
  endtask

  task automatic test_mult_signs();
    int cyc;
    do_op(3'b000, 32'hFFFF_FFF9, 32'd6, cyc);
    total++; if (hi !== 32'hFFFF_FFFF) $display("FAIL mult_neg_hi: got %h want %h", hi, 32'hFFFF_FFFF); else passed++;
    total++; if (lo !== 32'hFFFF_FFD6) $display("FAIL mult_neg_lo: got %h want %h", lo, 32'hFFFF_FFD6); else passed++;
    do_op(3'b000, 32'hFFFF_FFF9, 32'hFFFF_FFFA, cyc);
    total++; if (hi !== 32'd0) $display("FAIL mult_pos_hi: got %h want %h", hi, 32'd0); else passed++;
    total++; if (lo !== 32'd42) $display("FAIL mult_pos_lo: got %h want %h", lo, 32'd42); else passed++;
  endtask

  task automatic test_div_signs();
    int cyc;
    do_op(3'b010, 32'hFFFF_FFF9, 32'd2, cyc);
    total++; if (lo !== 32'hFFFF_FFFD) $display("FAIL div_neg_q: got %h want %h", lo, 32'hFFFF_FFFD); else passed++;
    total++; if (hi !== 32'hFFFF_FFFF) $display("FAIL div_neg_r: got %h want %h", hi, 32'hFFFF_FFFF); else passed++;
    do_op(3'b011, 32'd7, 32'd2, cyc);
    total++; if (lo !== 32'd3) $display("FAIL divu_q: got %h want %h", lo, 32'd3); else passed++;
    total++; if (hi !== 32'd1) $display("FAIL divu_r: got %h want %h", hi, 32'd1); else passed++;
    do_op(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, cyc);
    total++; if (lo !== 32'h8000_0000) $display("FAIL div_ovf_q: got %h want %h", lo, 32'h8000_0000); else passed++;
    total++; if (hi !== 32'd0) $display("FAIL div_ovf_r: got %h want %h", hi, 32'd0); else passed++;
  endtask

  task automatic test_div_zero();
    int cyc;
    do_op(3'b011, 32'd123, 32'd0, cyc);
    total++; if (cyc !== 33) $display("FAIL divu0_busy_cycles: got %0d want 33", cyc); else passed++;
    total++; if (hi !== 32'd123) $display("FAIL divu0_hi: got %h want %h", hi, 32'd123); else passed++;
    total++; if (lo !== 32'hFFFF_FFFF) $display("FAIL divu0_lo: got %h want %h", lo, 32'hFFFF_FFFF); else passed++;
    do_op(3'b010, 32'hFFFF_FFFB, 32'd0, cyc);
    total++; if (hi !== 32'hFFFF_FFFB) $display("FAIL div0_hi: got %h want %h", hi, 32'hFFFF_FFFB); else passed++;
    total++; if (lo !== 32'hFFFF_FFFF) $display("FAIL div0_lo: got %h want %h", lo, 32'hFFFF_FFFF); else passed++;
  endtask

  task automatic test_ignore_busy_mt_reserved();
    int cyc;
    @(negedge clk);
    muldiv_we = 1'b1; muldiv_op = 3'b000; a = 32'd2; b = 32'd3;
    @(posedge clk); #1;            // E0
    muldiv_we = 1'b0; a = 32'd0; b = 32'd0;
    repeat (4) @(posedge clk);     // E4
    #1;
    muldiv_we = 1'b1; muldiv_op = 3'b100; a = 32'd99;
    @(posedge clk); #1;            // E5: must be ignored
    muldiv_we = 1'b0;
    total++; if (hi !== 32'hFFFF_FFFB) $display("FAIL busy_mthi_ignored: got %h want %h", hi, 32'hFFFF_FFFB); else passed++;
    cyc = 0;
    while (busy && cyc < 60) begin cyc++; @(posedge clk); #1; end
    total++; if (cyc !== 28) $display("FAIL busy_remaining_cycles: got %0d want 28", cyc); else passed++;
    total++; if (hi !== 32'd0) $display("FAIL ign_mult_hi: got %h want %h", hi, 32'd0); else passed++;
    total++; if (lo !== 32'd6) $display("FAIL ign_mult_lo: got %h want %h", lo, 32'd6); else passed++;
    do_op(3'b101, 32'd77, 32'd0, cyc);
    total++; if (lo !== 32'd77) $display("FAIL mtlo_lo: got %h want %h", lo, 32'd77); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL mtlo_busy: got %b want 0", busy); else passed++;
    total++; if (hi !== 32'd0) $display("FAIL mtlo_hi_kept: got %h want %h", hi, 32'd0); else passed++;
    do_op(3'b110, 32'd55, 32'd66, cyc);
    total++; if (hi !== 32'd0) $display("FAIL rsvd_hi: got %h want %h", hi, 32'd0); else passed++;
    total++; if (lo !== 32'd77) $display("FAIL rsvd_lo: got %h want %h", lo, 32'd77); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL rsvd_busy: got %b want 0", busy); else passed++;
  endtask

  task automatic test_back_to_back();
    int cyc;
    do_op(3'b001, 32'd1000, 32'd1000, cyc);
    total++; if (lo !== 32'd1_000_000) $display("FAIL b2b_first_lo: got %h want %h", lo, 32'd1_000_000); else passed++;
    // Issued on the first idle edge (E34 of the previous op).
    do_op(3'b011, 32'd100, 32'd7, cyc);
    total++; if (cyc !== 33) $display("FAIL b2b_busy_cycles: got %0d want 33", cyc); else passed++;
    total++; if (hi !== 32'd2) $display("FAIL b2b_r: got %h want %h", hi, 32'd2); else passed++;
    total++; if (lo !== 32'd14) $display("FAIL b2b_q: got %h want %h", lo, 32'd14); else passed++;
  endtask

  initial begin
    test_reset();
    test_reset_mid_op();
    test_multu_overflow();
    test_mult_signs();
    test_div_signs();
    test_div_zero();
    test_ignore_busy_mt_reserved();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multiply/divide unit with the architectural HI/LO registers for the multicycle MIPS datapath.
- Consumes the controller's muldivOP/muldivWE strobe and the A/B operand registers (GPR[rs], GPR[rt]).
- Produces HI/LO for the mfhi/mflo writeback mux, plus a busy flag the controller uses to stall.
- Radix-2, one iteration per cycle, with shared magnitude/sign-fix logic for the signed variants.

Parameters:
- ITER, 32, number of iteration cycles in CALC; must equal the operand width, and only 32 is supported.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- muldiv_we  in  1  command strobe from controller; sampled on the rising edge.
- muldiv_op  in  3  command: 000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo, 11x reserved.
- a  in  32  rs operand (A register).
- b  in  32  rt operand (B register).
- hi  out  32  HI register.
- lo  out  32  LO register.
- busy  out  1  high while an operation is in progress; registered.

Behaviour:
- Reset: at any edge with reset=1:
  - hi=0, lo=0, busy=0, state=IDLE.
  - Any in-flight operation is discarded and HI/LO are not updated.
  - reset has priority over muldiv_we.
- Command acceptance:
  - A command is accepted only on an edge with muldiv_we=1 && busy=0 && reset=0.
  - muldiv_we while busy=1 is ignored completely; there is no queueing and operands are not recaptured.
  - Reserved ops (110, 111) are ignored and leave HI/LO unchanged.
- mthi / mtlo:
  - Complete on the accept edge: hi<=a (mthi) or lo<=a (mtlo).
  - busy stays 0 and the other register is unchanged.
- mult/multu/div/divu, state machine IDLE -> CALC -> FIX -> IDLE:
  - Accept edge E0: latch operands (as magnitudes for signed ops), record result signs, clear the iteration counter. State becomes CALC, busy becomes 1.
  - CALC: one shift-add (multiply) or restoring shift-subtract (divide) step per edge. After the ITER-th CALC edge (E32) the state becomes FIX.
  - FIX edge (E33): apply two's-complement sign correction and write hi/lo together. State becomes IDLE, busy becomes 0.
  - Result visible from the cycle after E33. Total busy-high time is 33 cycles.
  - hi/lo hold their old values for the whole operation; they are never partially updated.
- Multiply:
  - {hi,lo} = 64-bit product.
  - mult: signed x signed.
  - multu: unsigned x unsigned.
- Divide:
  - lo = quotient, hi = remainder.
  - div: quotient truncates toward zero; remainder takes the sign of the dividend (a).
  - divu: unsigned.
  - Divisor zero (div or divu): hi=a, lo=32'hFFFF_FFFF, same 33-cycle latency.
  - div overflow (a=32'h8000_0000, b=32'hFFFF_FFFF): lo=32'h8000_0000, hi=0.
- Operand independence:
  - a/b may change freely after E0; the result depends only on values sampled at E0.
- Back-to-back:
  - A new command may be accepted on the first edge where busy=0, i.e. E34 relative to the previous E0.
  - An mfhi read in the cycle after E33 sees the new value.

Test Plan:
- Reset mid-operation:
  - Sequence: mthi a=5, then multu a=3 b=4, then reset asserted at E10.
  - Required: hi=0, lo=0, busy=0 on the next cycle; a subsequent mflo-side read is 0.
- multu overflow into HI:
  - Stimulus: a=32'hFFFF_FFFF, b=32'hFFFF_FFFF.
  - Required: busy high for exactly 33 cycles, then hi=32'hFFFF_FFFE, lo=32'h0000_0001.
- mult signs:
  - a=-7 (32'hFFFF_FFF9), b=6 -> hi=32'hFFFF_FFFF, lo=32'hFFFF_FFD6.
  - a=-7, b=-6 -> hi=0, lo=42.
- div signs:
  - a=-7, b=2 -> lo=32'hFFFF_FFFD (-3), hi=32'hFFFF_FFFF (-1).
  - divu a=7, b=2 -> lo=3, hi=1.
  - div a=32'h8000_0000, b=-1 -> lo=32'h8000_0000, hi=0.
- Divide by zero:
  - divu a=123, b=0 -> hi=123, lo=32'hFFFF_FFFF after 33 cycles.
  - div a=-5, b=0 -> hi=32'hFFFF_FFFB, lo=32'hFFFF_FFFF.
- Ignore while busy / mt* / reserved:
  - Issue mult a=2 b=3, then pulse mthi a=99 at E5 -> hi=0, lo=6 at completion.
  - Then mtlo a=77 with busy=0 -> lo=77 the same cycle, busy stays 0.
  - Then op=110 -> no change to hi/lo.
